// File: rtl/mips_pkg.sv
// Shared definitions for the mips_pipe core: opcodes, instruction classes
// and instruction field helpers.
package mips_pkg;

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_SUB   = 6'b000001;
    localparam logic [5:0] OP_AND   = 6'b000010;
    localparam logic [5:0] OP_OR    = 6'b000011;
    localparam logic [5:0] OP_SLT   = 6'b000100;
    localparam logic [5:0] OP_MUL   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b001000;
    localparam logic [5:0] OP_SW    = 6'b001001;
    localparam logic [5:0] OP_ADDI  = 6'b001010;
    localparam logic [5:0] OP_SUBI  = 6'b001011;
    localparam logic [5:0] OP_SLTI  = 6'b001100;
    localparam logic [5:0] OP_BNEQZ = 6'b001101;
    localparam logic [5:0] OP_BEQZ  = 6'b001110;
    localparam logic [5:0] OP_HLT   = 6'b111111;

    // NOP is the encoding-zero class so an all-zero stage register is a bubble
    typedef enum logic [2:0] {
        NOP,
        RR_ALU,
        RM_ALU,
        LOAD,
        STORE,
        BRANCH,
        HALT
    } instr_class_e;

    function automatic logic [5:0] f_opcode(input logic [31:0] ir);
        return ir[31:26];
    endfunction

    function automatic logic [4:0] f_rs(input logic [31:0] ir);
        return ir[25:21];
    endfunction

    function automatic logic [4:0] f_rt(input logic [31:0] ir);
        return ir[20:16];
    endfunction

    function automatic logic [4:0] f_rd(input logic [31:0] ir);
        return ir[15:11];
    endfunction

    function automatic logic [15:0] f_imm(input logic [31:0] ir);
        return ir[15:0];
    endfunction

    // Undefined opcodes fall into HALT
    function automatic instr_class_e op_class(input logic [5:0] op);
        instr_class_e c;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: c = RR_ALU;
            OP_ADDI, OP_SUBI, OP_SLTI:                     c = RM_ALU;
            OP_LW:                                         c = LOAD;
            OP_SW:                                         c = STORE;
            OP_BNEQZ, OP_BEQZ:                             c = BRANCH;
            default:                                       c = HALT;
        endcase
        return c;
    endfunction

    function automatic logic uses_rs(input instr_class_e c);
        return c inside {RR_ALU, RM_ALU, LOAD, STORE, BRANCH};
    endfunction

    function automatic logic uses_rt(input instr_class_e c);
        return c inside {RR_ALU, STORE};
    endfunction

    function automatic logic writes_reg(input instr_class_e c);
        return c inside {RR_ALU, RM_ALU, LOAD};
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// Architectural register file.
// Ports: clk1; raddr1/rdata1 and raddr2/rdata2 operand reads; dbg_raddr/
// dbg_rdata debug read; we/waddr/wdata single write port. All reads are
// combinational and see a same-cycle write (write-through). r0 reads zero
// and ignores writes; indices alias modulo REG_N. Contents are not reset.
module mips_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_N  = 32
) (
    input  logic              clk1,
    input  logic [4:0]        raddr1,
    input  logic [4:0]        raddr2,
    input  logic [4:0]        dbg_raddr,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              we,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata
);
    localparam int unsigned RW = $clog2(REG_N);

    logic [DATA_W-1:0] regs [REG_N];
    logic [RW-1:0]     wa, a1, a2, ad;
    logic              wr_ok;

    assign wa    = RW'(waddr);
    assign a1    = RW'(raddr1);
    assign a2    = RW'(raddr2);
    assign ad    = RW'(dbg_raddr);
    assign wr_ok = we && (wa != '0);

    // Storage write
    always_ff @(posedge clk1) begin
        if (wr_ok) begin
            regs[wa] <= wdata;
        end
    end

    // Reads with write-through bypass and hardwired r0
    always_comb begin
        rdata1    = '0;
        rdata2    = '0;
        dbg_rdata = '0;
        if (a1 != '0) rdata1    = (wr_ok && wa == a1) ? wdata : regs[a1];
        if (a2 != '0) rdata2    = (wr_ok && wa == a2) ? wdata : regs[a2];
        if (ad != '0) dbg_rdata = (wr_ok && wa == ad) ? wdata : regs[ad];
    end

endmodule

// File: rtl/mips_pipe.sv
// Five-stage single-clock MIPS32 integer pipeline (IF, ID, EX, MEM, WB).
// Ports: clk1/rst (async active-high); imem_addr/imem_rdata instruction
// fetch; dmem_addr/dmem_wdata/dmem_we/dmem_rdata data memory from MEM;
// halted (sticky, HLT retired); retired (retired instruction count);
// dbg_raddr/dbg_rdata combinational debug register read.
module mips_pipe
    import mips_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_N    = 32,
    parameter int unsigned IMEM_AW  = 10,
    parameter int unsigned DMEM_AW  = 10,
    parameter int unsigned PC_RESET = 0
) (
    input  logic               clk1,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [DATA_W-1:0]  dmem_wdata,
    output logic               dmem_we,
    input  logic [DATA_W-1:0]  dmem_rdata,
    output logic               halted,
    output logic [31:0]        retired,
    input  logic [4:0]         dbg_raddr,
    output logic [DATA_W-1:0]  dbg_rdata
);
    localparam int unsigned RW = $clog2(REG_N);

    typedef struct packed {
        logic               valid;
        logic [31:0]        ir;
        logic [IMEM_AW-1:0] npc;
    } ifid_t;

    typedef struct packed {
        logic               valid;
        instr_class_e       cls;
        logic [5:0]         op;
        logic [RW-1:0]      rs;
        logic [RW-1:0]      rt;
        logic [RW-1:0]      dst;
        logic               wen;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [DATA_W-1:0]  imm;
        logic [IMEM_AW-1:0] npc;
    } idex_t;

    typedef struct packed {
        logic              valid;
        instr_class_e      cls;
        logic [RW-1:0]     dst;
        logic              wen;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] b;
    } exmem_t;

    typedef struct packed {
        logic              valid;
        instr_class_e      cls;
        logic [RW-1:0]     dst;
        logic              wen;
        logic [DATA_W-1:0] res;
    } memwb_t;

    logic [IMEM_AW-1:0] pc_q, pc_d;
    ifid_t              ifid_q, ifid_d;
    idex_t              idex_q, idex_d;
    exmem_t             exmem_q, exmem_d;
    memwb_t             memwb_q, memwb_d;
    logic               halted_d;
    logic [31:0]        retired_d;

    // ID stage decode and register read
    instr_class_e      id_cls;
    logic [RW-1:0]     id_rs, id_rt, id_dst;
    logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
    idex_t             id_pkt;

    mips_regfile #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regfile (
        .clk1      (clk1),
        .raddr1    (f_rs(ifid_q.ir)),
        .raddr2    (f_rt(ifid_q.ir)),
        .dbg_raddr (dbg_raddr),
        .rdata1    (rf_rdata1),
        .rdata2    (rf_rdata2),
        .dbg_rdata (dbg_rdata),
        .we        (memwb_q.valid && memwb_q.wen && !halted),
        .waddr     (5'(memwb_q.dst)),
        .wdata     (memwb_q.res)
    );

    always_comb begin
        id_cls = ifid_q.valid ? op_class(f_opcode(ifid_q.ir)) : NOP;
        id_rs  = RW'(f_rs(ifid_q.ir));
        id_rt  = RW'(f_rt(ifid_q.ir));
        id_dst = (id_cls == RR_ALU) ? RW'(f_rd(ifid_q.ir)) : id_rt;

        id_pkt       = '0;
        id_pkt.valid = ifid_q.valid;
        id_pkt.cls   = id_cls;
        id_pkt.op    = f_opcode(ifid_q.ir);
        id_pkt.rs    = id_rs;
        id_pkt.rt    = id_rt;
        id_pkt.dst   = id_dst;
        id_pkt.wen   = ifid_q.valid && writes_reg(id_cls) && (id_dst != '0);
        id_pkt.a     = rf_rdata1;
        id_pkt.b     = rf_rdata2;
        id_pkt.imm   = DATA_W'($signed(f_imm(ifid_q.ir)));
        id_pkt.npc   = ifid_q.npc;
    end

    // EX operand forwarding: EX/MEM (non-load) first, then MEM/WB
    logic [DATA_W-1:0] ex_a, ex_b;
    logic              fwd_em_ok, fwd_mw_ok;

    assign fwd_em_ok = exmem_q.valid && exmem_q.wen && (exmem_q.cls != LOAD);
    assign fwd_mw_ok = memwb_q.valid && memwb_q.wen;

    always_comb begin
        ex_a = idex_q.a;
        ex_b = idex_q.b;
        if (fwd_em_ok && exmem_q.dst == idex_q.rs)      ex_a = exmem_q.alu;
        else if (fwd_mw_ok && memwb_q.dst == idex_q.rs) ex_a = memwb_q.res;
        if (fwd_em_ok && exmem_q.dst == idex_q.rt)      ex_b = exmem_q.alu;
        else if (fwd_mw_ok && memwb_q.dst == idex_q.rt) ex_b = memwb_q.res;
    end

    // EX ALU and branch resolution
    logic [DATA_W-1:0]  ex_alu;
    logic               ex_taken;
    logic [IMEM_AW-1:0] ex_target;

    always_comb begin
        ex_alu = '0;
        case (idex_q.cls)
            RR_ALU: begin
                case (idex_q.op)
                    OP_ADD:  ex_alu = ex_a + ex_b;
                    OP_SUB:  ex_alu = ex_a - ex_b;
                    OP_AND:  ex_alu = ex_a & ex_b;
                    OP_OR:   ex_alu = ex_a | ex_b;
                    OP_SLT:  ex_alu = DATA_W'($signed(ex_a) < $signed(ex_b));
                    OP_MUL:  ex_alu = ex_a * ex_b;
                    default: ex_alu = '0;
                endcase
            end
            RM_ALU: begin
                case (idex_q.op)
                    OP_ADDI: ex_alu = ex_a + idex_q.imm;
                    OP_SUBI: ex_alu = ex_a - idex_q.imm;
                    OP_SLTI: ex_alu = DATA_W'($signed(ex_a) < $signed(idex_q.imm));
                    default: ex_alu = '0;
                endcase
            end
            LOAD, STORE: ex_alu = ex_a + idex_q.imm;
            default:     ex_alu = '0;
        endcase

        ex_taken  = idex_q.valid && (idex_q.cls == BRANCH) &&
                    ((idex_q.op == OP_BEQZ) ? (ex_a == '0) : (ex_a != '0));
        ex_target = idex_q.npc + IMEM_AW'(idex_q.imm);
    end

    // Hazards: load-use interlock and fetch freeze while any HLT is in flight
    logic load_use, halt_seen;

    assign load_use  = idex_q.valid && (idex_q.cls == LOAD) &&
                       ((uses_rs(id_cls) && id_rs == idex_q.dst) ||
                        (uses_rt(id_cls) && id_rt == idex_q.dst));
    assign halt_seen = (id_cls == HALT) ||
                       (idex_q.valid  && idex_q.cls  == HALT) ||
                       (exmem_q.valid && exmem_q.cls == HALT) ||
                       (memwb_q.valid && memwb_q.cls == HALT);

    // Next-state: everything holds once halted
    always_comb begin
        pc_d      = pc_q;
        ifid_d    = ifid_q;
        idex_d    = idex_q;
        exmem_d   = exmem_q;
        memwb_d   = memwb_q;
        halted_d  = halted;
        retired_d = retired;

        if (!halted) begin
            exmem_d.valid = idex_q.valid;
            exmem_d.cls   = idex_q.cls;
            exmem_d.dst   = idex_q.dst;
            exmem_d.wen   = idex_q.wen;
            exmem_d.alu   = ex_alu;
            exmem_d.b     = ex_b;

            memwb_d.valid = exmem_q.valid;
            memwb_d.cls   = exmem_q.cls;
            memwb_d.dst   = exmem_q.dst;
            memwb_d.wen   = exmem_q.wen;
            memwb_d.res   = (exmem_q.cls == LOAD) ? dmem_rdata : exmem_q.alu;

            if (memwb_q.valid) retired_d = retired + 32'd1;
            if (memwb_q.valid && memwb_q.cls == HALT) halted_d = 1'b1;

            // Taken branch beats both the interlock and the HLT freeze
            if (ex_taken) begin
                pc_d   = ex_target;
                ifid_d = '0;
                idex_d = '0;
            end else if (load_use) begin
                idex_d = '0;
            end else if (halt_seen) begin
                ifid_d = '0;
                idex_d = id_pkt;
            end else begin
                pc_d         = pc_q + IMEM_AW'(1);
                ifid_d.valid = 1'b1;
                ifid_d.ir    = imem_rdata;
                ifid_d.npc   = pc_q + IMEM_AW'(1);
                idex_d       = id_pkt;
            end
        end
    end

    // State registers
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            pc_q    <= IMEM_AW'(PC_RESET);
            ifid_q  <= '0;
            idex_q  <= '0;
            exmem_q <= '0;
            memwb_q <= '0;
            halted  <= 1'b0;
            retired <= '0;
        end else begin
            pc_q    <= pc_d;
            ifid_q  <= ifid_d;
            idex_q  <= idex_d;
            exmem_q <= exmem_d;
            memwb_q <= memwb_d;
            halted  <= halted_d;
            retired <= retired_d;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = DMEM_AW'(exmem_q.alu);
    assign dmem_wdata = exmem_q.b;
    assign dmem_we    = exmem_q.valid && (exmem_q.cls == STORE) && !halted;

endmodule

// File: doc/mips_pipe.md
# mips_pipe

Parametrised single-clock five-stage MIPS32 integer pipeline (IF, ID, EX, MEM, WB). It is the successor to the team's two-phase-clock core. It adds:
- asynchronous reset
- external instruction and data memory ports
- full EX forwarding
- a load-use interlock
- branch flush
- precise halt

It sits between the instruction ROM and the data RAM at the top of the CPU subsystem.

## Interface
Parameters:
- DATA_W, 32, datapath and register width; must be ≥ 16.
- REG_N, 32, number of architectural registers; power of two, ≤ 32; r0 reads zero.
- IMEM_AW, 10, instruction word-address width.
- DMEM_AW, 10, data word-address width.
- PC_RESET, 0, PC value after reset.

Ports:
- clk1  in  1  sole clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- imem_addr  out  IMEM_AW  fetch address (= PC).
- imem_rdata  in  32  instruction word, combinational read of imem_addr.
- dmem_addr  out  DMEM_AW  data word address from MEM stage.
- dmem_wdata  out  DATA_W  store data.
- dmem_we  out  1  store strobe, one cycle per SW.
- dmem_rdata  in  DATA_W  load data, combinational read of dmem_addr.
- halted  out  1  sticky; set when HLT retires.
- retired  out  32  count of retired non-bubble instructions, including HLT.
- dbg_raddr  in  5  debug register index.
- dbg_rdata  out  DATA_W  combinational regfile read of dbg_raddr.

## Operation
- ISA and encoding are unchanged:
  - opcode is [31:26]; rs is [25:21]; rt is [20:16]; rd is [15:11]; imm is [15:0], sign-extended to DATA_W.
  - RR ops (ADD, SUB, AND, OR, SLT, MUL) write rd.
  - RM ops (ADDI, SUBI, SLTI) write rt.
  - LW writes rt with dmem_rdata.
  - SW stores rt to rs+imm.
- SLT and SLTI compare signed and produce 0 or 1. MUL keeps the low DATA_W bits. All arithmetic wraps modulo 2^DATA_W.
- Register indices ≥ REG_N alias modulo REG_N. Writes to r0 are discarded.
- Branches are BEQZ (taken if rs==0) and BNEQZ (taken if rs!=0). Target = NPC + imm, truncated to IMEM_AW. A branch resolves in EX.
- A taken branch turns the IF/ID and ID/EX instructions into bubbles and loads the PC with the target.
- Forwarding into the EX operands uses this priority: EX/MEM result, then MEM/WB result, then the ID-latched value.
  - Loads forward only from MEM/WB.
  - The regfile is write-through, so a WB write is seen by the same-cycle ID read.
- Load-use interlock: if the ID instruction sources the rt of an LW in EX, then for 1 cycle PC and IF/ID hold and ID/EX receives a bubble.
- Undefined opcodes decode as HLT.
- HLT behaviour:
  - When HLT is in ID, fetch freezes: the PC holds and IF/ID loads bubbles.
  - Older instructions drain. halted rises when HLT is in WB.
  - After that, no pipeline register, PC or memory state changes.
  - A HLT flushed by a taken branch has no effect.
- dmem_we is only asserted for a valid (non-bubble) SW in MEM, and is never asserted after halted.

## Timing
- Reset values:
  - PC = PC_RESET.
  - All stage valid bits = 0; all pipeline registers are bubbles.
  - halted = 0, retired = 0, dmem_we = 0.
  - Regfile contents are not reset.
- Reset asserted mid-operation discards in-flight instructions the same instant. No store completes after rst rises.
- Latency and throughput:
  - An instruction fetched at cycle n writes back at cycle n+4.
  - Steady-state throughput is 1 per cycle.
- Penalties: a taken branch costs 2 bubbles; a load-use hazard costs 1 bubble; a not-taken branch costs 0.
- Same-cycle branch-taken and load-use stall: the branch wins, and the stalled ID instruction is flushed.
- PC increments wrap at 2^IMEM_AW.

## Structure
- mips_pkg holds:
  - opcode localparams;
  - the instruction class enum (RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP);
  - field-slice helper functions.
- Sub-module mips_regfile (parameters DATA_W, REG_N) provides:
  - two read ports plus the debug read port;
  - one write port with write-through;
  - r0 hardwired to zero.
- Hazard and forward logic stays in mips_pipe.

## Test plan
- **Forwarding:** ADDI r1,r0,5; ADDI r2,r0,7; ADD r3,r1,r2; SUB r4,r3,r1; HLT → r3=12, r4=7, no stall cycles, retired=5.
- **Load-use:** memory word 20 = 0x55; ADDI r1,r0,20; LW r2,0(r1); ADD r3,r2,r2 → exactly one bubble, r3=0xAA, dmem_we never high.
- **Branch flush:** r1=0; BEQZ r1,+2; ADDI r5,r0,1; ADDI r6,r0,1; ADDI r7,r0,9 → r5=r6=0, r7=9.
- **BNEQZ loop:** counter r1=3; loop SUBI r1,r1,1 / BNEQZ r1,-2 → 3 iterations, r1=0, halt after fall-through HLT.
- **Halt and undefined opcode:**
  - SW after HLT in program order never asserts dmem_we.
  - Opcode 6'b010101 halts with halted=1 and retired frozen.
- **Reset:** rst pulsed mid-loop with a SW in MEM → no write, PC=PC_RESET, halted=0. Also run a DATA_W=16 build of the loop test.
